// File: rtl/cpu_wb_scheduler.sv
// -----------------------------------------------------------------------------
// cpu_wb_scheduler
//
// Arbitrates the single register-file write port between N_REQ writeback
// sources (0 = ALU, 1 = load/store, 2 = mul/div) and tracks outstanding
// writes per architectural register for the issue stage.
//
// Round-robin arbitration: the search starts at the pointer, ascends and
// wraps. The winner is registered onto the write port one cycle later.
// Each register has a small pending counter. An accepted issue increments
// it. A committing write decrements it. The counters drive the RAW/WAW stall
// status outputs.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   req_valid[N_REQ]       requester i holds a writeback
//   req_ready[N_REQ]       requester i granted this cycle (one-hot or zero)
//   req_rd[5*N_REQ]        destination register of requester i
//   req_data[XLEN*N_REQ]   write data of requester i
//   rd_addr/rd_data        registered register-file write address/data
//   rd_write_en            registered register-file write strobe
//   issue_en/issue_rd      instruction issuing with destination issue_rd
//   rs1_query/rs2_query    source registers of the candidate instruction
//   rs1_busy/rs2_busy      source has an outstanding write
//   issue_full             issue_rd counter saturated, issue must stall
//   dbg_pending            bit r set when xr has any outstanding write
// -----------------------------------------------------------------------------
module cpu_wb_scheduler #(
    parameter int XLEN  = 32,
    parameter int N_REQ = 3,
    parameter int CNT_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [5*N_REQ-1:0]      req_rd,
    input  logic [XLEN*N_REQ-1:0]   req_data,
    output logic [4:0]              rd_addr,
    output logic [XLEN-1:0]         rd_data,
    output logic                    rd_write_en,
    input  logic                    issue_en,
    input  logic [4:0]              issue_rd,
    input  logic [4:0]              rs1_query,
    input  logic [4:0]              rs2_query,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    issue_full,
    output logic [31:0]             dbg_pending
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Arbitration state and registered write port
    logic [PTR_W-1:0]   ptr_r;
    logic [4:0]         rd_addr_r;
    logic [XLEN-1:0]    rd_data_r;
    logic               rd_write_en_r;

    // Arbitration results
    logic               grant_found_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [PTR_W-1:0]   ptr_next_s;
    logic [N_REQ-1:0]   req_ready_s;
    logic [4:0]         sel_rd_s;
    logic [XLEN-1:0]    sel_data_s;

    // Scoreboard
    logic [CNT_W-1:0]   cnt_r [32];
    logic [31:0]        inc_s;
    logic [31:0]        dec_s;
    logic               issue_full_s;
    logic               rs1_busy_s;
    logic               rs2_busy_s;
    logic [31:0]        pending_s;
    logic               dec_err_s;

    // Requester index reached by stepping 'offs' places past 'base', wrapping at N_REQ
    function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        sum = (sum >= N_REQ) ? (sum - N_REQ) : sum;
        return PTR_W'(sum);
    endfunction

    // Round-robin search from ptr_r; the first valid requester wins
    always_comb begin
        logic [PTR_W-1:0] cand_v;
        logic             hit_v;
        grant_found_s = 1'b0;
        grant_idx_s   = {PTR_W{1'b0}};
        cand_v        = {PTR_W{1'b0}};
        hit_v         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_v        = rr_index(ptr_r, k);
            hit_v         = !grant_found_s && req_valid[cand_v];
            grant_idx_s   = hit_v ? cand_v : grant_idx_s;
            grant_found_s = grant_found_s | hit_v;
        end
    end

    // One-hot ready, winner's payload and the pointer value after a grant
    always_comb begin
        req_ready_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            req_ready_s[i] = grant_found_s && (grant_idx_s == PTR_W'(i));
        end
        sel_rd_s   = req_rd[5*grant_idx_s +: 5];
        sel_data_s = req_data[XLEN*grant_idx_s +: XLEN];
        ptr_next_s = (grant_idx_s == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}}
                                                         : (grant_idx_s + PTR_W'(1));
    end

    // Register the granted writeback onto the write port and advance the pointer.
    // A write to x0 is accepted but never strobes the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r         <= {PTR_W{1'b0}};
            rd_addr_r     <= 5'd0;
            rd_data_r     <= {XLEN{1'b0}};
            rd_write_en_r <= 1'b0;
        end else if (grant_found_s) begin
            ptr_r         <= ptr_next_s;
            rd_addr_r     <= sel_rd_s;
            rd_data_r     <= sel_data_s;
            rd_write_en_r <= (sel_rd_s != 5'd0);
        end else begin
            ptr_r         <= ptr_r;
            rd_addr_r     <= rd_addr_r;
            rd_data_r     <= rd_data_r;
            rd_write_en_r <= 1'b0;
        end
    end

    // Per-register increment (accepted issue) and decrement (commit) requests.
    // Neither can ever target x0, so cnt_r[0] stays at zero.
    always_comb begin
        inc_s = 32'd0;
        dec_s = 32'd0;
        for (int r = 0; r < 32; r++) begin
            inc_s[r] = issue_en && (issue_rd == 5'(r)) && (r != 0) && !issue_full_s;
            dec_s[r] = rd_write_en_r && (rd_addr_r == 5'(r));
        end
    end

    // Pending counters: the decrement lands on the same edge the register file
    // commits, so busy drops exactly when the new value becomes readable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                case ({inc_s[r], dec_s[r]})
                    2'b10:   cnt_r[r] <= cnt_r[r] + CNT_ONE;
                    2'b01:   cnt_r[r] <= (cnt_r[r] == CNT_ZERO) ? CNT_ZERO : (cnt_r[r] - CNT_ONE);
                    default: cnt_r[r] <= cnt_r[r];
                endcase
            end
        end
    end

    // Hazard status derived from the counters
    always_comb begin
        issue_full_s = (cnt_r[issue_rd] == CNT_MAX);
        rs1_busy_s   = (cnt_r[rs1_query] != CNT_ZERO);
        rs2_busy_s   = (cnt_r[rs2_query] != CNT_ZERO);
        pending_s    = 32'd0;
        for (int r = 1; r < 32; r++) begin
            pending_s[r] = (cnt_r[r] != CNT_ZERO);
        end
        dec_err_s    = rd_write_en_r && (cnt_r[rd_addr_r] == CNT_ZERO);
    end

`ifndef SYNTHESIS
    // Flag a commit to a register that had no outstanding write
    always_ff @(posedge clk) begin
        if (!reset && dec_err_s) begin
            $error("ERROR cpu_wb_scheduler: writeback to x%0d with no pending write", rd_addr_r);
        end
    end
`endif

    assign req_ready   = req_ready_s;
    assign rd_addr     = rd_addr_r;
    assign rd_data     = rd_data_r;
    assign rd_write_en = rd_write_en_r;
    assign issue_full  = issue_full_s;
    assign rs1_busy    = rs1_busy_s;
    assign rs2_busy    = rs2_busy_s;
    assign dbg_pending = pending_s;

endmodule

// File: tb/tb_cpu_wb_scheduler.sv
// Self-checking bench for cpu_wb_scheduler: directed scenarios followed by
// random traffic, with a reference model of counters, pointer and expected
// writebacks. Registered writebacks are checked by a separate monitor.
module tb_cpu_wb_scheduler;

    localparam int XLEN  = 32;
    localparam int N_REQ = 3;
    localparam int CNT_W = 2;
    localparam int MAXC  = 3;

    logic                  clk;
    logic                  reset;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [5*N_REQ-1:0]    req_rd;
    logic [XLEN*N_REQ-1:0] req_data;
    logic [4:0]            rd_addr;
    logic [XLEN-1:0]       rd_data;
    logic                  rd_write_en;
    logic                  issue_en;
    logic [4:0]            issue_rd;
    logic [4:0]            rs1_query;
    logic [4:0]            rs2_query;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  issue_full;
    logic [31:0]           dbg_pending;

    cpu_wb_scheduler #(.XLEN(XLEN), .N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_write_en(rd_write_en),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .rs1_query(rs1_query), .rs2_query(rs2_query),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_full(issue_full), .dbg_pending(dbg_pending)
    );

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        int              edge_no;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_t;
    wb_t exp_q[$];

    // Reference model
    int m_cnt[32];
    int m_ptr;
    int m_commit;
    int outstanding[$];

    // Requester behaviour: hold request until granted
    bit              rq_busy[N_REQ];
    logic [4:0]      rq_rd[N_REQ];
    logic [XLEN-1:0] rq_data[N_REQ];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_dbg();
        logic [31:0] v;
        v = 32'd0;
        for (int r = 1; r < 32; r++) v[r] = (m_cnt[r] != 0);
        return v;
    endfunction

    task automatic apply();
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]             = rq_busy[i];
            req_rd[5*i +: 5]         = rq_rd[i];
            req_data[XLEN*i +: XLEN] = rq_data[i];
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_ptr    = 0;
        m_commit = 0;
        outstanding.delete();
        exp_q.delete();
        for (int i = 0; i < N_REQ; i++) begin
            rq_busy[i] = 1'b0;
            rq_rd[i]   = 5'd0;
            rq_data[i] = 32'd0;
        end
    endtask

    // One clock cycle: entered just after a negedge, returns at the next negedge
    task automatic cycle();
        int              g;
        logic [N_REQ-1:0] exp_ready;
        logic [4:0]      grd;
        bit              inc;
        apply();
        #1;
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % N_REQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("rs1_busy", rs1_busy, m_cnt[rs1_query] != 0);
        check("rs2_busy", rs2_busy, m_cnt[rs2_query] != 0);
        check("issue_full", issue_full, m_cnt[issue_rd] == MAXC);
        check("dbg_pending", dbg_pending, exp_dbg());
        inc = issue_en && (issue_rd != 5'd0) && (m_cnt[issue_rd] != MAXC);
        if (inc) begin
            m_cnt[issue_rd]++;
            outstanding.push_back(int'(issue_rd));
        end
        if (m_commit != 0 && m_cnt[m_commit] > 0) m_cnt[m_commit]--;
        m_commit = 0;
        if (g >= 0) begin
            m_ptr = (g + 1) % N_REQ;
            grd   = req_rd[5*g +: 5];
            if (grd != 5'd0) begin
                exp_q.push_back('{edge_cnt + 1, grd, req_data[XLEN*g +: XLEN]});
                m_commit = int'(grd);
            end
            rq_busy[g] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit mid);
        if (mid) #1;
        reset = 1'b1;
        if (mid) begin
            #1;
            check("rst_mid_we", rd_write_en, 1'b0);
            check("rst_mid_pending", dbg_pending, 32'd0);
            check("rst_mid_addr", rd_addr, 5'd0);
        end
        model_clear();
        issue_en  = 1'b0;
        issue_rd  = 5'd0;
        rs1_query = 5'd0;
        rs2_query = 5'd0;
        apply();
        @(negedge clk);
        @(negedge clk);
        if (!mid) begin
            check("rst_we", rd_write_en, 1'b0);
            check("rst_addr", rd_addr, 5'd0);
            check("rst_data", rd_data, 32'd0);
            check("rst_pending", dbg_pending, 32'd0);
            check("rst_ready", req_ready, 3'b000);
        end
        reset = 1'b0;
    endtask

    // Writeback monitor: every strobe must match the oldest expected write at its edge
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) begin
                checks++;
                failures++;
                $display("FAIL wb_missing: got no write expected x%0d data 0x%0h", exp_q[0].addr, exp_q[0].data);
                void'(exp_q.pop_front());
            end
            if (rd_write_en === 1'b1) begin
                if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
                    e = exp_q.pop_front();
                    check("wb_addr", rd_addr, e.addr);
                    check("wb_data", rd_data, e.data);
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: got write x%0d expected no write", rd_addr);
                end
            end
        end
    end

    initial begin
        int wave[6];
        reset     = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        issue_en  = 1'b0;
        issue_rd  = 5'd0;
        rs1_query = 5'd0;
        rs2_query = 5'd0;
        do_reset(1'b0);

        // Single writeback from requester 0 (issued in the same cycle)
        rq_busy[0] = 1'b1; rq_rd[0] = 5'd5; rq_data[0] = 32'hDEADBEEF;
        issue_en = 1'b1; issue_rd = 5'd5;
        cycle();
        issue_en = 1'b0;
        check("t1_we", rd_write_en, 1'b1);
        check("t1_addr", rd_addr, 5'd5);
        check("t1_data", rd_data, 32'hDEADBEEF);
        cycle();
        check("t1_we_off", rd_write_en, 1'b0);
        outstanding.delete();

        // Three requesters continuously valid for six grants
        do_reset(1'b0);
        wave = '{10, 11, 12, 13, 14, 15};
        for (int k = 0; k < 6; k++) begin
            issue_en = 1'b1; issue_rd = 5'(wave[k]);
            cycle();
        end
        issue_en = 1'b0;
        outstanding.delete();
        for (int i = 0; i < N_REQ; i++) begin
            rq_busy[i] = 1'b1; rq_rd[i] = 5'(wave[i]); rq_data[i] = $urandom;
        end
        for (int k = 0; k < 6; k++) begin
            cycle();
            for (int i = 0; i < N_REQ; i++) begin
                if (!rq_busy[i] && k < 3) begin
                    rq_busy[i] = 1'b1; rq_rd[i] = 5'(wave[i+3]); rq_data[i] = $urandom;
                end
            end
        end
        cycle();
        cycle();

        // RAW busy on x7 cleared by requester 2
        issue_en = 1'b1; issue_rd = 5'd7; rs1_query = 5'd7;
        cycle();
        issue_en = 1'b0;
        outstanding.delete();
        cycle();
        rq_busy[2] = 1'b1; rq_rd[2] = 5'd7; rq_data[2] = 32'h0000_0777;
        cycle();
        check("t3_we", rd_write_en, 1'b1);
        check("t3_busy_during_wb", rs1_busy, 1'b1);
        cycle();
        check("t3_busy_after_wb", rs1_busy, 1'b0);

        // Saturation of x9
        issue_rd = 5'd9;
        for (int k = 0; k < 4; k++) begin
            issue_en = 1'b1;
            cycle();
            if (k == 2) check("t4_full_at_3", issue_full, 1'b1);
        end
        issue_en = 1'b0;
        outstanding.delete();
        check("t4_full_after_4th", issue_full, 1'b1);
        rq_busy[0] = 1'b1; rq_rd[0] = 5'd9; rq_data[0] = 32'h0000_0999;
        cycle();
        check("t4_still_full", issue_full, 1'b1);
        cycle();
        check("t4_not_full", issue_full, 1'b0);
        rq_busy[0] = 1'b1; rq_rd[0] = 5'd9; rq_data[0] = 32'h0000_0998;
        cycle();
        rq_busy[1] = 1'b1; rq_rd[1] = 5'd9; rq_data[1] = 32'h0000_0997;
        cycle();
        cycle();
        cycle();

        // Writeback to x0 from requester 1
        rq_busy[1] = 1'b1; rq_rd[1] = 5'd0; rq_data[1] = 32'h0000_1234;
        cycle();
        check("t5_we", rd_write_en, 1'b0);
        for (int i = 0; i < N_REQ; i++) begin
            rq_busy[i] = 1'b1; rq_rd[i] = 5'd0; rq_data[i] = $urandom;
        end
        apply();
        #1;
        check("t5_ptr_at_2", req_ready, 3'b100);
        cycle();
        cycle();
        cycle();

        // Issue and commit on x3 in the same cycle, then reset mid-cycle
        do_reset(1'b0);
        issue_en = 1'b1; issue_rd = 5'd3; rs1_query = 5'd3;
        cycle();
        issue_en = 1'b0;
        rq_busy[0] = 1'b1; rq_rd[0] = 5'd3; rq_data[0] = 32'h0000_0333;
        cycle();
        issue_en = 1'b1;
        rq_busy[0] = 1'b1; rq_rd[0] = 5'd3; rq_data[0] = 32'h0000_0334;
        cycle();
        issue_en = 1'b0;
        check("t6_busy_kept", rs1_busy, 1'b1);
        check("t6_pending", dbg_pending, 32'h0000_0008);
        check("t6_we_pending", rd_write_en, 1'b1);
        do_reset(1'b1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset(1'b1);
            for (int i = 0; i < N_REQ; i++) begin
                if (!rq_busy[i] && $urandom_range(0, 2) == 0) begin
                    if (outstanding.size() > 0 && $urandom_range(0, 4) != 0) begin
                        int j;
                        j = $urandom_range(0, outstanding.size() - 1);
                        rq_rd[i] = 5'(outstanding[j]);
                        outstanding.delete(j);
                    end else begin
                        rq_rd[i] = 5'd0;
                    end
                    rq_busy[i] = 1'b1;
                    rq_data[i] = $urandom;
                end
            end
            issue_en  = 1'($urandom_range(0, 1));
            issue_rd  = 5'($urandom_range(0, 7));
            rs1_query = 5'($urandom_range(0, 7));
            rs2_query = 5'($urandom_range(0, 7));
            cycle();
        end

        // Drain all outstanding writes
        issue_en = 1'b0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!rq_busy[i] && outstanding.size() > 0) begin
                    rq_rd[i]   = 5'(outstanding.pop_front());
                    rq_busy[i] = 1'b1;
                    rq_data[i] = $urandom;
                end
            end
            cycle();
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_pending", dbg_pending, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_wb_scheduler.md
Name: cpu_wb_scheduler

Overview:
- Shares the single write port of the general-purpose register file between N_REQ writeback sources (index 0 = ALU, 1 = load/store unit, 2 = mul/div unit) using round-robin arbitration.
- Drives the register file write port from registers.
- Keeps a per-register pending-write scoreboard so the issue stage can stall on RAW and WAW hazards.
- Sits between the execution units and the register file; issue logic queries it each cycle.

Parameters:
- XLEN, 32, data width (32 or 64).
- N_REQ, 3, number of writeback requesters (2..4).
- CNT_W, 2, width of each per-register pending counter (max outstanding writes per register = 2^CNT_W-1).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  requester i has a writeback pending.
- req_ready  output  N_REQ  requester i's writeback accepted this cycle.
- req_rd  input  5*N_REQ  destination register of requester i, in bits [5i+4:5i].
- req_data  input  XLEN*N_REQ  write data of requester i, in bits [XLEN*i+XLEN-1:XLEN*i].
- rd_addr  output  5  register file write address.
- rd_data  output  XLEN  register file write data.
- rd_write_en  output  1  register file write strobe.
- issue_en  input  1  an instruction with destination issue_rd issues this cycle.
- issue_rd  input  5  destination of the issuing instruction.
- rs1_query  input  5  source register 1 of the candidate instruction.
- rs2_query  input  5  source register 2 of the candidate instruction.
- rs1_busy  output  1  rs1_query has an outstanding write.
- rs2_busy  output  1  rs2_query has an outstanding write.
- issue_full  output  1  issue_rd's pending counter is saturated; issue must stall.
- dbg_pending  output  32  bit r = (pending count of xr != 0).

Behaviour:
- Reset (async) values:
  - rd_write_en=0, rd_addr=0, rd_data=0.
  - RR pointer=0.
  - All pending counters=0.
  - Therefore rs1_busy, rs2_busy, issue_full and dbg_pending are all 0.
- Arbitration (combinational within the cycle):
  - Search req_valid starting at index ptr, ascending, wrapping mod N_REQ.
  - The first valid index g is granted, and req_ready[g]=1.
  - All other req_ready bits are 0; req_ready is 0 for every requester when nothing is valid.
  - req_ready never depends on rd_write_en; the port accepts one write per cycle, every cycle.
- Handshake and registered output:
  - On a clk edge where requester g is granted: ptr <= (g+1) mod N_REQ.
  - On the same edge: rd_addr <= req_rd[g] and rd_data <= req_data[g].
  - rd_write_en <= 1 if req_rd[g] != 0, else 0.
  - Latency: handshake cycle N gives rd_write_en high in cycle N+1, and the register file updates at the end of N+1.
  - No grant: rd_write_en <= 0, ptr holds; rd_addr and rd_data hold their last value.
  - A requester holds req_valid, req_rd and req_data stable until it sees req_ready.
- Scoreboard, counter cnt[r] for r = 1..31 (cnt[0] is constant 0):
  - inc[r] = issue_en && issue_rd==r && r!=0 && !issue_full.
  - dec[r] = rd_write_en && rd_addr==r.
  - Both inc and dec: unchanged. inc only: +1. dec only: -1.
  - An issue_en while issue_full is high is ignored; the counter is not incremented.
  - dec with cnt==0 is a protocol error: the counter stays at 0, and a `ERROR` log is emitted in simulation.
  - The decrement happens on the same edge the register file commits, so busy clears exactly when the new value is readable. No forwarding is required.
- Status outputs (combinational from the counters):
  - rs1_busy = cnt[rs1_query] != 0; rs2_busy likewise.
  - x0 is never busy.
  - issue_full = (cnt[issue_rd] == 2^CNT_W-1).
- Writeback to x0:
  - Accepted normally (req_ready high, ptr advances).
  - rd_write_en stays 0 and no counter changes.
- Simultaneous events:
  - Issue and writeback to the same register in the same cycle leave the count unchanged; the register stays busy if the count is nonzero.
  - Multiple valid requesters: exactly one is granted per cycle, and each waits at most N_REQ-1 cycles.
- Reset asserted mid-operation:
  - All state clears immediately.
  - Any registered write not yet committed is dropped (rd_write_en=0).

Test Plan:
1. Reset, then req_valid=3'b001, req_rd[0]=5, req_data[0]=0xDEADBEEF -> req_ready=001 in cycle 0; in cycle 1 rd_write_en=1, rd_addr=5, rd_data=0xDEADBEEF; in cycle 2 rd_write_en=0.
2. All three requesters held valid for 6 cycles -> grant order 0,1,2,0,1,2, one req_ready bit per cycle, and rd_write_en high for 6 consecutive cycles starting at cycle 1.
3. issue_en with issue_rd=7, then rs1_query=7 -> rs1_busy=1; requester 2 writes x7 -> rs1_busy stays 1 through the rd_write_en cycle and is 0 in the following cycle.
4. Three issues to x9 without writeback -> cnt=3 and issue_full=1; a fourth issue_en leaves cnt=3; one writeback to x9 -> issue_full=0 in the following cycle.
5. Requester 1 writes x0 with data 0x1234 -> req_ready[1]=1 and ptr advances to 2; rd_write_en stays 0 and dbg_pending is unchanged.
6. Issue to x3 and writeback to x3 in the same cycle with cnt[3]=1 -> cnt stays 1; assert reset in the next cycle -> dbg_pending=0 and rd_write_en=0 immediately, with no clock edge needed.
